// File: rtl/acc_cpu_pkg.sv
// Shared types and constants for the accumulator CPU: opcodes, FSM states,
// SKIP condition codes, ALU selects and small opcode classification helpers.
package acc_cpu_pkg;

  typedef enum logic [3:0] {
    OP_HALT  = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_NOT   = 4'h7,
    OP_CLEAR = 4'h8,
    OP_SKIP  = 4'h9,
    OP_JUMP  = 4'hA,
    OP_ADDI  = 4'hB,
    OP_SUBI  = 4'hC,
    OP_ANDI  = 4'hD,
    OP_ORI   = 4'hE,
    OP_NOP   = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_OPRD,
    ST_EXEC,
    ST_STORE,
    ST_HALTED
  } state_t;

  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_NOT  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b101;

  // Opcodes that need a second memory read before they can execute.
  function automatic logic is_mem_op(input opcode_t op);
    return op inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

  function automatic logic writes_ac(input opcode_t op);
    return op inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
                      OP_CLEAR, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI};
  endfunction

  function automatic logic [2:0] alu_sel_of(input opcode_t op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB, OP_SUBI: return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/acc_cpu_core_alu.sv
// Combinational accumulator ALU; PASS forwards operand b (used by LOAD and CLEAR).
module acc_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2:0]            sel,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = b;
    case (sel)
      ALU_AND:  y = a & b;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_NOT:  y = ~a;
      ALU_OR:   y = a | b;
      default:  y = b;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: FSM, PC, IR and AC driving a single-port synchronous
// RAM with one cycle of read latency.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  halted,
  output logic                  retire,
  output logic [ADDR_WIDTH-1:0] pc_dbg,
  output logic [DATA_WIDTH-1:0] ac_dbg
);

  localparam int OPW = DATA_WIDTH - ADDR_WIDTH;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0]   ir;
  logic [DATA_WIDTH-1:0]   ac;
  logic                    retire_q;

  opcode_t                 dec_op;
  opcode_t                 ex_op;
  logic [ADDR_WIDTH-1:0]   dec_opnd;
  logic [ADDR_WIDTH-1:0]   ex_opnd;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic [DATA_WIDTH-1:0]   alu_y;
  logic                    skip_taken;
  logic [ADDR_WIDTH-1:0]   pc_exec;

  // In DECODE the fetched word is still on mem_rdata, so steer from it directly.
  assign dec_op   = opcode_t'(mem_rdata[DATA_WIDTH-1 -: OPW]);
  assign dec_opnd = mem_rdata[ADDR_WIDTH-1:0];
  assign ex_op    = opcode_t'(ir[DATA_WIDTH-1 -: OPW]);
  assign ex_opnd  = ir[ADDR_WIDTH-1:0];

  always_comb begin
    alu_b = {{OPW{1'b0}}, ex_opnd};
    if (is_mem_op(ex_op))
      alu_b = mem_rdata;
    else if (ex_op == OP_CLEAR)
      alu_b = '0;
  end

  acc_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .sel (alu_sel_of(ex_op)),
    .a   (ac),
    .b   (alu_b),
    .y   (alu_y)
  );

  always_comb begin
    skip_taken = 1'b0;
    case (ex_opnd[ADDR_WIDTH-1 -: 2])
      SKIP_NEG:  skip_taken = ac[DATA_WIDTH-1];
      SKIP_ZERO: skip_taken = (ac == '0);
      SKIP_POS:  skip_taken = !ac[DATA_WIDTH-1] && (ac != '0);
      default:   skip_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_exec = pc;
    if (ex_op == OP_JUMP)
      pc_exec = ex_opnd;
    else if (ex_op == OP_SKIP && skip_taken)
      pc_exec = pc + 1'b1;
  end

  // Memory strobes are registered and set on entry to FETCH, OPRD or STORE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      ac        <= '0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      retire_q <= 1'b0;
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (run) begin
            state    <= ST_FETCH;
            mem_addr <= pc;
            mem_re   <= 1'b1;
            halted   <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          ir <= mem_rdata;
          pc <= pc + 1'b1;
          if (dec_op == OP_HALT) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else if (dec_op == OP_STORE) begin
            state     <= ST_STORE;
            mem_addr  <= dec_opnd;
            mem_we    <= 1'b1;
            mem_wdata <= ac;
            retire_q  <= 1'b1;
          end else if (is_mem_op(dec_op)) begin
            state    <= ST_OPRD;
            mem_addr <= dec_opnd;
            mem_re   <= 1'b1;
          end else begin
            state    <= ST_EXEC;
            retire_q <= 1'b1;
          end
        end
        ST_OPRD: begin
          state    <= ST_EXEC;
          retire_q <= 1'b1;
        end
        ST_EXEC: begin
          if (writes_ac(ex_op))
            ac <= alu_y;
          pc       <= pc_exec;
          state    <= ST_FETCH;
          mem_addr <= pc_exec;
          mem_re   <= 1'b1;
        end
        ST_STORE: begin
          state    <= ST_FETCH;
          mem_addr <= pc;
          mem_re   <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // HALT has no later state to retire in, so its pulse comes straight from DECODE.
  assign retire = retire_q || (state == ST_DECODE && dec_op == OP_HALT);
  assign pc_dbg = pc;
  assign ac_dbg = ac;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: vector table, directed multi-cycle
// sequences and random programs checked against an instruction-level model.
module tb_acc_cpu_core;

  localparam int              DW  = 16;
  localparam int              AW  = 12;
  localparam logic [AW-1:0]   RPC = 12'h100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          halted;
  logic          retire;
  logic [AW-1:0] pc_dbg;
  logic [DW-1:0] ac_dbg;

  logic [DW-1:0] mem  [0:4095];
  logic [DW-1:0] mmem [0:4095];
  logic          ld_en   = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0][15:0] prog;
    logic [15:0]      exp_ac;
    logic [11:0]      exp_pc;
    logic [7:0]       exp_ret;
  } vec_t;

  vec_t vecs[$];

  acc_cpu_core #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESET_PC  (RPC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .halted   (halted),
    .retire   (retire),
    .pc_dbg   (pc_dbg),
    .ac_dbg   (ac_dbg)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with a side door for loading programs.
  always @(posedge clk) begin
    if (ld_en)
      mem[ld_addr] <= ld_data;
    else if (mem_we)
      mem[mem_addr] <= mem_wdata;
    if (mem_re)
      mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic writeMem(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
    mmem[a] = d;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Resets, pulses run, then follows the core until it halts or the budget runs out.
  task automatic runProgram(output int lat, output int ret, output bit ov,
                            output bit to, output bit fetch_ok);
    doReset();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    fetch_ok = mem_re && !mem_we && (mem_addr == RPC);
    lat = -1;
    ret = 0;
    ov  = 1'b0;
    to  = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (mem_re && mem_we) ov = 1'b1;
      if (retire) begin
        ret++;
        if (lat < 0) lat = i;
      end
      if (halted) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Instruction-level reference: one loop iteration per instruction.
  task automatic modelRun(output logic [15:0] ac, output logic [11:0] pc, output int ret);
    logic [15:0] ins;
    logic [3:0]  op;
    logic [11:0] a;
    logic        take;
    bit          done;
    ac = '0;
    pc = RPC;
    ret = 0;
    done = 1'b0;
    for (int s = 0; s < 10000 && !done; s++) begin
      ins = mmem[pc];
      op  = ins[15:12];
      a   = ins[11:0];
      pc  = pc + 12'd1;
      ret++;
      case (op)
        4'h0: done = 1'b1;
        4'h1: ac = mmem[a];
        4'h2: mmem[a] = ac;
        4'h3: ac = ac + mmem[a];
        4'h4: ac = ac - mmem[a];
        4'h5: ac = ac & mmem[a];
        4'h6: ac = ac | mmem[a];
        4'h7: ac = ~ac;
        4'h8: ac = '0;
        4'h9: begin
          case (a[11:10])
            2'd0:    take = $signed(ac) < 0;
            2'd1:    take = (ac == 16'h0);
            2'd2:    take = $signed(ac) > 0;
            default: take = 1'b0;
          endcase
          if (take) pc = pc + 12'd1;
        end
        4'hA: pc = a;
        4'hB: ac = ac + {4'h0, a};
        4'hC: ac = ac - {4'h0, a};
        4'hD: ac = ac & {4'h0, a};
        4'hE: ac = ac | {4'h0, a};
        default: ;
      endcase
    end
  endtask

  function automatic vec_t mkVec(input logic [15:0] w0, w1, w2, w3, w4, w5, w6,
                                 input logic [15:0] ac, input logic [11:0] pc,
                                 input logic [7:0] ret);
    vec_t v;
    v.prog    = '0;
    v.prog[0] = w0;
    v.prog[1] = w1;
    v.prog[2] = w2;
    v.prog[3] = w3;
    v.prog[4] = w4;
    v.prog[5] = w5;
    v.prog[6] = w6;
    v.exp_ac  = ac;
    v.exp_pc  = pc;
    v.exp_ret = ret;
    return v;
  endfunction

  task automatic applyStimulus(input int idx, input vec_t v);
    int lat, ret;
    bit ov, to, fok;
    for (int i = 0; i < 8; i++) writeMem(RPC + 12'(i), v.prog[i]);
    runProgram(lat, ret, ov, to, fok);
    checkOutput($sformatf("vec%0d_halt", idx), 32'(to), 32'd0);
    checkOutput($sformatf("vec%0d_ac", idx), 32'(ac_dbg), 32'(v.exp_ac));
    checkOutput($sformatf("vec%0d_pc", idx), 32'(pc_dbg), 32'(v.exp_pc));
    checkOutput($sformatf("vec%0d_retire", idx), 32'(ret), 32'(v.exp_ret));
  endtask

  initial begin
    int            lat, ret, mret;
    bit            ov, to, fok, quiet, seen;
    logic [15:0]   mac;
    logic [11:0]   mpc;
    logic [15:0]   setup_w, skip_w, acv;
    logic [3:0]    ops [14];
    logic [3:0]    op;
    logic [11:0]   opnd;
    int            len;
    bit            taken;

    ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
            4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    // Reset state, sampled while reset is still held.
    repeat (2) @(negedge clk);
    checkOutput("rst_pc", 32'(pc_dbg), 32'h100);
    checkOutput("rst_ac", 32'(ac_dbg), 32'h0);
    checkOutput("rst_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_re_we", {30'h0, mem_re, mem_we}, 32'h0);
    checkOutput("rst_wdata", 32'(mem_wdata), 32'h0);
    checkOutput("rst_halt_ret", {30'h0, halted, retire}, 32'h0);
    rst = 1'b0;

    // Vector table: immediates and every SKIP code against AC = -1, 0, +1.
    vecs.push_back(mkVec(16'h8000, 16'hC010, 16'h0000, 0, 0, 0, 0, 16'hFFF0, 12'h103, 3));
    vecs.push_back(mkVec(16'h8000, 16'hC010, 16'hE00F, 16'h0000, 0, 0, 0, 16'hFFFF, 12'h104, 4));
    vecs.push_back(mkVec(16'h8000, 16'hC010, 16'hE00F, 16'hB001, 16'h0000, 0, 0, 16'h0000, 12'h105, 5));
    vecs.push_back(mkVec(16'h8000, 16'hC010, 16'hE00F, 16'hB001, 16'hC001, 16'h0000, 0, 16'hFFFF, 12'h106, 6));
    vecs.push_back(mkVec(16'h8000, 16'hC010, 16'hE00F, 16'hB001, 16'hC001, 16'hD0F0, 16'h0000, 16'h00F0, 12'h107, 7));
    vecs.push_back(mkVec(16'h8000, 16'h7000, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 12'h103, 3));
    for (int c = 0; c < 4; c++) begin
      for (int v = 0; v < 3; v++) begin
        setup_w = (v == 0) ? 16'hC001 : (v == 1) ? 16'hF000 : 16'hB001;
        acv     = (v == 0) ? 16'hFFFF : (v == 1) ? 16'h0000 : 16'h0001;
        skip_w  = {4'h9, 2'(c), 10'h000};
        taken   = (c == 0 && v == 0) || (c == 1 && v == 1) || (c == 2 && v == 2);
        vecs.push_back(mkVec(16'h8000, setup_w, skip_w, 16'h0000, 16'h0000, 0, 0,
                             acv, taken ? 12'h105 : 12'h104, 4));
      end
    end
    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Load/add/store program plus first-instruction latency for a memory op.
    writeMem(12'h100, 16'h1110);
    writeMem(12'h101, 16'h3111);
    writeMem(12'h102, 16'h2112);
    writeMem(12'h103, 16'h0000);
    writeMem(12'h110, 16'd5);
    writeMem(12'h111, 16'd7);
    writeMem(12'h112, 16'd0);
    runProgram(lat, ret, ov, to, fok);
    checkOutput("las_fetch", 32'(fok), 32'd1);
    checkOutput("las_latency", 32'(lat), 32'd3);
    checkOutput("las_halted", {31'h0, halted}, 32'd1);
    checkOutput("las_result", 32'(mem[12'h112]), 32'h000C);
    checkOutput("las_pc", 32'(pc_dbg), 32'h104);
    checkOutput("las_retire", 32'(ret), 32'd4);
    checkOutput("las_excl", 32'(ov), 32'd0);

    // Multiply 7 by 5 with a SUBI / SKIP-zero / JUMP loop.
    writeMem(12'h100, 16'h8000);
    writeMem(12'h101, 16'h2202);
    writeMem(12'h102, 16'h1202);
    writeMem(12'h103, 16'h3201);
    writeMem(12'h104, 16'h2202);
    writeMem(12'h105, 16'h1200);
    writeMem(12'h106, 16'hC001);
    writeMem(12'h107, 16'h2200);
    writeMem(12'h108, 16'h9400);
    writeMem(12'h109, 16'hA102);
    writeMem(12'h10A, 16'h1202);
    writeMem(12'h10B, 16'h0000);
    writeMem(12'h200, 16'd5);
    writeMem(12'h201, 16'd7);
    writeMem(12'h202, 16'd0);
    modelRun(mac, mpc, mret);
    runProgram(lat, ret, ov, to, fok);
    checkOutput("mul_halt", 32'(to), 32'd0);
    checkOutput("mul_ac", 32'(ac_dbg), 32'h0023);
    checkOutput("mul_mem", 32'(mem[12'h202]), 32'h0023);
    checkOutput("mul_pc", 32'(pc_dbg), 32'h10C);
    checkOutput("mul_retire", 32'(ret), 32'(mret));

    // JUMP to the top of memory; NOP there wraps PC to 0.
    writeMem(12'h100, 16'hAFFF);
    writeMem(12'hFFF, 16'hF000);
    writeMem(12'h000, 16'h0000);
    runProgram(lat, ret, ov, to, fok);
    checkOutput("wrap_latency", 32'(lat), 32'd2);
    checkOutput("wrap_pc", 32'(pc_dbg), 32'h001);
    checkOutput("wrap_retire", 32'(ret), 32'd3);

    // Self-modifying code: STORE overwrites the very next instruction.
    writeMem(12'h100, 16'h1200);
    writeMem(12'h101, 16'h2102);
    writeMem(12'h102, 16'h0000);
    writeMem(12'h103, 16'h0000);
    writeMem(12'h200, 16'hB007);
    runProgram(lat, ret, ov, to, fok);
    checkOutput("smc_ac", 32'(ac_dbg), 32'hB00E);
    checkOutput("smc_pc", 32'(pc_dbg), 32'h104);

    // Reset asserted while a STORE is on the bus.
    writeMem(12'h100, 16'h8000);
    writeMem(12'h101, 16'hB005);
    writeMem(12'h102, 16'h2210);
    writeMem(12'h103, 16'h0000);
    doReset();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_we) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("rs_store_seen", 32'(seen), 32'd1);
    checkOutput("rs_store_addr", 32'(mem_addr), 32'h210);
    checkOutput("rs_store_data", 32'(mem_wdata), 32'h0005);
    rst = 1'b1;
    #1;
    checkOutput("rs_we_drop", {31'h0, mem_we}, 32'd0);
    checkOutput("rs_ac", 32'(ac_dbg), 32'h0);
    checkOutput("rs_pc", 32'(pc_dbg), 32'h100);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (mem_re || mem_we || retire || halted) quiet = 1'b0;
    end
    checkOutput("rs_idle_quiet", 32'(quiet), 32'd1);
    checkOutput("rs_idle_pc", 32'(pc_dbg), 32'h100);

    // Random straight-line programs against the instruction-level model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) writeMem(12'h200 + 12'(i), 16'($urandom));
      len = $urandom_range(3, 12);
      for (int i = 0; i < len; i++) begin
        op = ops[$urandom_range(0, 13)];
        if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6})
          opnd = 12'h200 + 12'($urandom_range(0, 15));
        else
          opnd = 12'($urandom_range(0, 4095));
        writeMem(RPC + 12'(i), {op, opnd});
      end
      writeMem(RPC + 12'(len), 16'h0000);
      writeMem(RPC + 12'(len + 1), 16'h0000);
      modelRun(mac, mpc, mret);
      runProgram(lat, ret, ov, to, fok);
      checkOutput($sformatf("rnd%0d_halt", t), 32'(to), 32'd0);
      checkOutput($sformatf("rnd%0d_ac", t), 32'(ac_dbg), 32'(mac));
      checkOutput($sformatf("rnd%0d_pc", t), 32'(pc_dbg), 32'(mpc));
      checkOutput($sformatf("rnd%0d_retire", t), 32'(ret), 32'(mret));
      checkOutput($sformatf("rnd%0d_excl", t), 32'(ov), 32'd0);
      for (int i = 0; i < 16; i++)
        checkOutput($sformatf("rnd%0d_m%0d", t, i), 32'(mem[12'h200 + 12'(i)]),
                    32'(mmem[12'h200 + 12'(i)]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Synthesisable, parametrised accumulator CPU core: fetches, decodes and executes a 16-opcode accumulator ISA against an external single-port synchronous RAM (1-cycle read latency). It is the hardware successor to our bench-driven fetch/execute sequencing. The FSM, registers (PC, IR, AC) and run/halt handshake live in RTL, and immediate-mode and conditional-skip behaviour is defined precisely.

## Interface
- DATA_WIDTH, 16: word width of AC, IR and the memory data bus; must equal 4 + ADDR_WIDTH.
- ADDR_WIDTH, 12: width of PC, memory address and instruction operand field.
- RESET_PC, 'h100: PC value after reset.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  start/resume request; sampled in IDLE and HALTED.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_re  out  1  read strobe; rdata valid the following cycle.
- mem_we  out  1  write strobe; RAM writes mem_wdata at mem_addr this edge.
- mem_wdata  out  DATA_WIDTH  write data (= AC).
- mem_rdata  in  DATA_WIDTH  read data.
- halted  out  1  high while in HALTED.
- retire  out  1  one-cycle pulse when an instruction completes.
- pc_dbg, ac_dbg  out  ADDR_WIDTH / DATA_WIDTH  current PC and AC.

## Operation
- Instruction = {op[3:0], opnd[ADDR_WIDTH-1:0]}; immediates are opnd zero-extended to DATA_WIDTH.
- Opcodes: 0 HALT, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 NOT, 8 CLEAR, 9 SKIP, A JUMP, B ADDI, C SUBI, D ANDI, E ORI, F NOP.
- LOAD/ADD/SUB/AND/OR read M[opnd] and write AC ← M, AC+M, AC−M, AC&M, AC|M. NOT: AC ← ~AC. CLEAR: AC ← 0.
- SKIP: opnd[11:10] (top two operand bits) 00 skip if AC<0 (signed), 01 if AC==0, 10 if AC>0 (signed), 11 never. A skip adds an extra +1 to PC.
- JUMP: PC ← opnd. HALT: PC is not advanced past HALT again; next run resumes at PC (instruction after HALT).
- Arithmetic is modulo 2^DATA_WIDTH (no flags); PC arithmetic is modulo 2^ADDR_WIDTH, so PC wraps from all-ones to 0.
- States: IDLE → (run) FETCH → DECODE → {OPRD → EXEC | EXEC | STORE | HALTED} → FETCH. HALTED → (run) FETCH.
- FETCH: mem_addr=PC, mem_re=1. DECODE: IR ← mem_rdata, PC ← PC+1. Memory-operand ops go to OPRD; STORE goes to STORE; HALT goes to HALTED; all others go to EXEC.
- OPRD: mem_addr=opnd, mem_re=1. EXEC: update AC/PC using mem_rdata or IR. STORE: mem_addr=opnd, mem_we=1, mem_wdata=AC.
- Reset values: PC=RESET_PC, AC=0, IR=0, state IDLE, mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0, halted=0, retire=0.

## Timing
- Latency from FETCH entry to retire: 3 cycles for register/immediate/JUMP/SKIP/NOP/STORE; 4 cycles for LOAD/ADD/SUB/AND/OR.
- retire is asserted in the final state of each instruction (EXEC or STORE). HALT retires in DECODE; halted rises the next cycle.
- mem_re and mem_we are never asserted together; both are 0 in IDLE, DECODE, EXEC and HALTED.
- run held high continuously causes no extra effect; only IDLE/HALTED sample it, and the restart FETCH occurs the cycle after run is seen.
- Reset mid-instruction (including during STORE) drops mem_we immediately, with no completion guarantee for the in-flight write.
- Self-modifying code: a STORE to PC's address is visible to the next FETCH.

## Structure
- acc_cpu_pkg holds: opcode enum, state enum, SKIP condition constants, ALU select constants (000 AND, 001 ADD, 010 SUB, 100 OR, 011 NOT, 101 PASS).
- Sub-module acc_alu (combinational, DATA_WIDTH-parametrised) computes AC results; the core owns FSM, PC, IR and AC.

## Test plan
- Reset then run, program at 'h100 "LOAD 'h110; ADD 'h111; STORE 'h112; HALT", with M['h110]=5, M['h111]=7 -> M['h112]=12, halted=1, PC='h104, 4 retire pulses.
- Multiply loop: 7 added 5 times via SUBI/SKIP(01)/JUMP -> AC='h0023, M[result]='h0023.
- Immediates: AC='hFFF0, ORI 'h00F -> 'hFFFF; ADDI 1 -> 'h0000 (wrap); SUBI 1 -> 'hFFFF; ANDI 'h0F0 -> 'h00F0.
- SKIP each code with AC = −1, 0, +1 -> PC advances by 2 only for the matching condition; code 11 never skips.
- JUMP to 'hFFF followed by NOP at 'hFFF -> PC wraps to 'h000.
- Assert rst during STORE -> mem_we=0 same cycle, AC=0, PC='h100, state IDLE; no activity until run.
